// File: rtl/timelock_host_pkg.sv
// Shared definitions for the timelock host sequencer and the controller it talks to.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package timelock_host_pkg;

    // Nibble command protocol opcodes, carried in the low nibble of every byte
    localparam logic [3:0] OP_LOAD       = 4'h1;
    localparam logic [3:0] OP_ACKLOAD    = 4'h2;
    localparam logic [3:0] OP_COMPUTE    = 4'h3;
    localparam logic [3:0] OP_ACKCOMPUTE = 4'h4;

    // Nibbles per operand (operand width is four times this)
    localparam int NIBBLES_DEFAULT = 92;

    // Width of the optional response-wait counter
    localparam int TMO_W = 25;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SEND_X   = 3'd1,
        ST_WAIT_X   = 3'd2,
        ST_SEND_CMP = 3'd3,
        ST_WAIT_CMP = 3'd4,
        ST_SEND_RD  = 3'd5,
        ST_WAIT_RD  = 3'd6
    } state_t;

endpackage

// File: rtl/timelock_host_nibble_shift_reg.sv
// Wide shift register: parallel load, 4-bit shift-in at the MSB end, shift-out from the LSB end.
// Latency: load or shift visible one cycle after the request.
// Backpressure: none; load has priority over shift.
module nibble_shift_reg #(
    parameter int W = 368
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_dat,
    input  logic         shift,
    input  logic [3:0]   shift_in,
    output logic [W-1:0] q
);

    // Parallel load wins; otherwise shift right by one nibble, new nibble entering at the top
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= load_dat;
        end else if (shift) begin
            q <= {shift_in, q[W-1:4]};
        end
    end

endmodule

// File: rtl/timelock_host.sv
// Host-side sequencer: loads operand x nibble-by-nibble, issues COMPUTE, reads back y (optional timeout: TIMELOCK_HOST_TIMEOUT_EN).
// Latency: first byte offered the cycle after start; each next byte no earlier than the cycle after its ack.
// Backpressure: holds in SEND states while tx_ready is low; waits in WAIT states for the ack (or timeout).
module timelock_host
    import timelock_host_pkg::*;
#(
    parameter int NIBBLES        = NIBBLES_DEFAULT,
    parameter int TIMEOUT_CYCLES = 2**24
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [4*NIBBLES-1:0] x_in,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [4*NIBBLES-1:0] y_out,
    input  logic                 tx_ready,
    output logic                 tx_new_byte,
    output logic [7:0]           tx_byte,
    input  logic                 rx_new_byte,
    input  logic [7:0]           rx_byte
);

    localparam int W = 4 * NIBBLES;

    state_t       state;
    logic [6:0]   cnt;
    logic [W-1:0] x_q;
    logic [W-1:0] y_q;

    logic last_nib;
    logic ack_load;
    logic ack_cmp;
    logic start_acc;
    logic x_shift;
    logic y_shift;
    logic tmo_hit;
    logic unused_x;

    assign last_nib  = (cnt == 7'(NIBBLES - 1));
    assign ack_load  = (rx_byte[3:0] == OP_ACKLOAD);
    assign ack_cmp   = (rx_byte[3:0] == OP_ACKCOMPUTE);
    assign start_acc = (state == ST_IDLE) && start;
    assign x_shift   = (state == ST_WAIT_X)  && rx_new_byte && ack_load;
    assign y_shift   = (state == ST_WAIT_RD) && rx_new_byte && ack_load;

    // Only the bottom nibble of the operand register is ever transmitted
    assign unused_x = ^x_q[W-1:4];

    nibble_shift_reg #(.W(W)) u_x_sr (
        .clk      (clk),
        .rst      (rst),
        .load     (start_acc),
        .load_dat (x_in),
        .shift    (x_shift),
        .shift_in (4'h0),
        .q        (x_q)
    );

    nibble_shift_reg #(.W(W)) u_y_sr (
        .clk      (clk),
        .rst      (rst),
        .load     (start_acc),
        .load_dat ('0),
        .shift    (y_shift),
        .shift_in (rx_byte[7:4]),
        .q        (y_q)
    );

`ifdef TIMELOCK_HOST_TIMEOUT_EN
    logic             in_wait;
    logic [TMO_W-1:0] tmo_cnt;

    assign in_wait = (state == ST_WAIT_X) || (state == ST_WAIT_CMP) || (state == ST_WAIT_RD);
    assign tmo_hit = in_wait && !rx_new_byte && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

    // Count cycles spent waiting for a response; restarts whenever the state changes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt <= '0;
        end else if (!in_wait || rx_new_byte || tmo_hit) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
    end
`else
    logic unused_tmo;
    assign unused_tmo = ^TIMEOUT_CYCLES;
    assign tmo_hit    = 1'b0;
`endif

    // Offer exactly one byte per SEND visit, in the cycle the transmitter is ready
    always_comb begin
        tx_new_byte = 1'b0;
        tx_byte     = 8'h00;
        if (tx_ready) begin
            case (state)
                ST_SEND_X:   begin tx_new_byte = 1'b1; tx_byte = {x_q[3:0], OP_LOAD};    end
                ST_SEND_CMP: begin tx_new_byte = 1'b1; tx_byte = {4'h0,     OP_COMPUTE}; end
                ST_SEND_RD:  begin tx_new_byte = 1'b1; tx_byte = {4'h0,     OP_LOAD};    end
                default:     begin tx_new_byte = 1'b0; tx_byte = 8'h00;                   end
            endcase
        end
    end

    // Protocol sequencer with registered status outputs; any bad ack or timeout aborts to IDLE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            error <= 1'b0;
            y_out <= '0;
        end else begin
            done <= 1'b0;
            if (tmo_hit) begin
                error <= 1'b1;
                busy  <= 1'b0;
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            cnt   <= '0;
                            error <= 1'b0;
                            busy  <= 1'b1;
                            state <= ST_SEND_X;
                        end
                    end
                    ST_SEND_X:   if (tx_ready) state <= ST_WAIT_X;
                    ST_SEND_CMP: if (tx_ready) state <= ST_WAIT_CMP;
                    ST_SEND_RD:  if (tx_ready) state <= ST_WAIT_RD;
                    ST_WAIT_X: begin
                        if (rx_new_byte) begin
                            if (!ack_load) begin
                                error <= 1'b1;
                                busy  <= 1'b0;
                                state <= ST_IDLE;
                            end else if (last_nib) begin
                                state <= ST_SEND_CMP;
                            end else begin
                                cnt   <= cnt + 7'd1;
                                state <= ST_SEND_X;
                            end
                        end
                    end
                    ST_WAIT_CMP: begin
                        if (rx_new_byte) begin
                            if (!ack_cmp) begin
                                error <= 1'b1;
                                busy  <= 1'b0;
                                state <= ST_IDLE;
                            end else begin
                                cnt   <= '0;
                                state <= ST_SEND_RD;
                            end
                        end
                    end
                    ST_WAIT_RD: begin
                        if (rx_new_byte) begin
                            if (!ack_load) begin
                                error <= 1'b1;
                                busy  <= 1'b0;
                                state <= ST_IDLE;
                            end else if (last_nib) begin
                                y_out <= {rx_byte[7:4], y_q[W-1:4]};
                                done  <= 1'b1;
                                busy  <= 1'b0;
                                state <= ST_IDLE;
                            end else begin
                                cnt   <= cnt + 7'd1;
                                state <= ST_SEND_RD;
                            end
                        end
                    end
                    default: begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_timelock_host.sv
// Bench for timelock_host: responder model answers every transmitted byte; scoreboard queues hold expected tx bytes and y.
// Latency: responder acks loads after a per-vector delay, COMPUTE after 20 cycles.
// Backpressure: tx_ready driven by the bench sequences.
module tb_timelock_host;

    localparam int NIB = 92;
    localparam int W   = 4 * NIB;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] x_in;
    logic         busy;
    logic         done;
    logic         error;
    logic [W-1:0] y_out;
    logic         tx_ready;
    logic         tx_new_byte;
    logic [7:0]   tx_byte;
    logic         rx_new_byte;
    logic [7:0]   rx_byte;

    timelock_host #(.NIBBLES(NIB), .TIMEOUT_CYCLES(100)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .x_in        (x_in),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .y_out       (y_out),
        .tx_ready    (tx_ready),
        .tx_new_byte (tx_new_byte),
        .tx_byte     (tx_byte),
        .rx_new_byte (rx_new_byte),
        .rx_byte     (rx_byte)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] x;
        int           pay;
        int           bad;
        int           dly;
    } vec_t;

    vec_t         tbl[6];
    logic [7:0]   exp_tx[$];
    logic [W-1:0] exp_y[$];
    logic [W-1:0] last_y;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int tx_cnt = 0;
    int done_cnt = 0;
    int resp_cd = 0;
    logic [7:0] resp_byte = 8'h00;
    int cur_pay = 0;
    int cur_bad = -1;
    int cur_dly = 1;
    bit cur_no_cmp = 1'b0;
    bit stray_now = 1'b0;
    int cmp_cyc = 0;

    task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Schedule the responder's answer to transmitted byte number k of the current transaction
    task automatic respond(input int k);
        logic [7:0] b;
        if (k < NIB)       b = 8'h02;
        else if (k == NIB) b = 8'h04;
        else               b = {4'(k - NIB - 1 + cur_pay), 4'h2};
        if (k == cur_bad) b = b ^ 8'h06;
        if (k == NIB && cur_no_cmp) begin
            resp_cd = 0;
        end else begin
            resp_byte = b;
            resp_cd   = (k == NIB) ? 20 : cur_dly;
        end
    endtask

    // One clock: responder/monitor work at the falling edge, status checks 1 ns after the rising edge
    task automatic cycle();
        cyc++;
        @(negedge clk);
        rx_new_byte = 1'b0;
        if (resp_cd > 0) begin
            resp_cd--;
            if (resp_cd == 0) begin
                rx_new_byte = 1'b1;
                rx_byte     = resp_byte;
            end
        end
        if (stray_now) begin
            rx_new_byte = 1'b1;
            rx_byte     = 8'h02;
            stray_now   = 1'b0;
        end
        if (tx_new_byte) begin
            if (exp_tx.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL tx_unexpected: got byte %02h, none expected", tx_byte);
            end else begin
                check("tx_byte", W'(tx_byte), W'(exp_tx.pop_front()));
            end
            if (tx_cnt == NIB) cmp_cyc = cyc;
            respond(tx_cnt);
            tx_cnt++;
        end
        @(posedge clk);
        #1;
        if (done) begin
            done_cnt++;
            if (exp_y.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL done_unexpected: got done=1, expected 0");
            end else begin
                last_y = exp_y.pop_front();
                check("y_out_at_done", y_out, last_y);
                check("busy_at_done", W'(busy), W'(0));
            end
        end
    endtask

    // Push the expected byte stream and result, then pulse start for one cycle
    task automatic start_txn(input logic [W-1:0] x, input int pay, input int bad, input int dly, input bit no_cmp);
        int n;
        logic [W-1:0] y;
        cur_pay = pay; cur_bad = bad; cur_dly = dly; cur_no_cmp = no_cmp;
        tx_cnt = 0; done_cnt = 0; resp_cd = 0;
        exp_tx.delete();
        n = (bad >= 0) ? bad + 1 : (no_cmp ? NIB + 1 : 2 * NIB + 1);
        for (int k = 0; k < n; k++) begin
            if (k < NIB)       exp_tx.push_back({x[4*k +: 4], 4'h1});
            else if (k == NIB) exp_tx.push_back(8'h03);
            else               exp_tx.push_back(8'h01);
        end
        if (bad < 0 && !no_cmp) begin
            for (int i = 0; i < NIB; i++) y[4*i +: 4] = 4'(i + pay);
            exp_y.push_back(y);
        end
        x_in  = x;
        start = 1'b1;
        cycle();
        start = 1'b0;
        check("busy_after_start", W'(busy), W'(1));
    endtask

    task automatic wait_end(input int budget);
        int n = 0;
        while (!(done_cnt > 0 || error) && n < budget) begin
            cycle();
            n++;
        end
        if (n >= budget) begin
            n_vec++;
            n_err++;
            $display("FAIL wait_bound: got no done/error within %0d cycles, expected one", budget);
        end
    endtask

    task automatic run_vec(input vec_t v);
        start_txn(v.x, v.pay, v.bad, v.dly, 1'b0);
        wait_end(3000);
        repeat (20) cycle();
        check("error", W'(error), W'(v.bad >= 0));
        check("busy_end", W'(busy), W'(0));
        check("tx_count", W'(tx_cnt), W'((v.bad >= 0) ? v.bad + 1 : 2 * NIB + 1));
        check("done_count", W'(done_cnt), W'(v.bad < 0));
        check("tx_queue_left", W'(exp_tx.size()), W'(0));
        check("y_out_hold", y_out, last_y);
    endtask

    function automatic logic [W-1:0] rand_x();
        logic [W-1:0] r;
        for (int i = 0; i < NIB; i++) r[4*i +: 4] = 4'($urandom);
        return r;
    endfunction

    initial begin
        logic [W-1:0] xb;
        rst = 1'b1; start = 1'b0; x_in = '0; tx_ready = 1'b1;
        rx_new_byte = 1'b0; rx_byte = 8'h00; last_y = '0;
        cycle(); cycle();
        check("rst_busy",  W'(busy),        W'(0));
        check("rst_done",  W'(done),        W'(0));
        check("rst_error", W'(error),       W'(0));
        check("rst_txnb",  W'(tx_new_byte), W'(0));
        check("rst_txb",   W'(tx_byte),     W'(0));
        check("rst_y",     y_out,           '0);
        rst = 1'b0;
        cycle();

        tbl[0] = '{x: W'(2),      pay: 0,  bad: -1,  dly: 1};
        tbl[1] = '{x: rand_x(),   pay: 5,  bad: -1,  dly: 3};
        tbl[2] = '{x: '1,         pay: 15, bad: 4,   dly: 1};
        tbl[3] = '{x: rand_x(),   pay: 9,  bad: NIB, dly: 2};
        tbl[4] = '{x: rand_x(),   pay: 1,  bad: 150, dly: 1};
        tbl[5] = '{x: rand_x(),   pay: 11, bad: 0,   dly: 2};
        for (int i = 0; i < 6; i++) run_vec(tbl[i]);

        // Back-pressure with a stray ack and a start while busy, both of which must be ignored
        xb = rand_x();
        tx_ready = 1'b0;
        start_txn(xb, 3, -1, 2, 1'b0);
        for (int i = 1; i <= 50; i++) begin
            if (i == 10) stray_now = 1'b1;
            if (i == 20) begin start = 1'b1; x_in = ~xb; end
            if (i == 21) start = 1'b0;
            cycle();
        end
        check("bp_no_tx", W'(tx_cnt), W'(0));
        tx_ready = 1'b1;
        cycle();
        check("bp_first_tx", W'(tx_cnt), W'(1));
        cycle();
        check("bp_single_tx", W'(tx_cnt), W'(1));
        wait_end(3000);
        repeat (20) cycle();
        check("bp_error", W'(error), W'(0));
        check("bp_tx_count", W'(tx_cnt), W'(2 * NIB + 1));
        check("bp_done_count", W'(done_cnt), W'(1));

        // Reset in the middle of the load phase
        start_txn(rand_x(), 7, -1, 1, 1'b0);
        for (int n = 0; n < 1000 && tx_cnt < 40; n++) cycle();
        check("mid_tx_count", W'(tx_cnt), W'(40));
        rst = 1'b1;
        #1;
        check("mrst_busy",  W'(busy),        W'(0));
        check("mrst_done",  W'(done),        W'(0));
        check("mrst_error", W'(error),       W'(0));
        check("mrst_txnb",  W'(tx_new_byte), W'(0));
        check("mrst_txb",   W'(tx_byte),     W'(0));
        check("mrst_y",     y_out,           '0);
        exp_tx.delete(); exp_y.delete(); resp_cd = 0; last_y = '0;
        cycle(); cycle();
        rst = 1'b0;
        tx_cnt = 0;
        repeat (5) cycle();
        check("post_rst_no_tx", W'(tx_cnt), W'(0));
        run_vec('{x: rand_x(), pay: 13, bad: -1, dly: 1});

`ifdef TIMELOCK_HOST_TIMEOUT_EN
        // COMPUTE never answered: error exactly 100 cycles after entering WAIT_CMP
        start_txn(rand_x(), 0, -1, 1, 1'b1);
        wait_end(1000);
        check("tmo_error", W'(error), W'(1));
        check("tmo_delay", W'(cyc - cmp_cyc), W'(100));
        repeat (10) cycle();
        check("tmo_tx_count", W'(tx_cnt), W'(NIB + 1));
        check("tmo_done", W'(done_cnt), W'(0));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
